// File: rtl/aidc_lite_decomp_ctrl.sv
// AIDC-Lite decompressor front end: packet prefix dispatch, raw unpack, engine write collection into 512b lines.
// Optional macro AIDC_LITE_DCTRL_DBUF_EN adds a second (ping-pong) line buffer.
module aidc_lite_decomp_ctrl #(
  parameter int NUM_ENG     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_sop,
  input  logic               s_eop,
  input  logic [31:0]        s_data,
  output logic [NUM_ENG-1:0] eng_valid,
  output logic               eng_sop,
  output logic               eng_eop,
  output logic [31:0]        eng_data,
  input  logic               wr_valid,
  input  logic [3:0]         wr_addr,
  input  logic [63:0]        wr_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [511:0]       m_data,
  output logic               m_err,
  output logic [2:0]         err_o,
  input  logic               err_clr
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUT} state_t;
  typedef enum logic [1:0] {M_ENG, M_RAW, M_DROP} mode_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] NE = 3'(NUM_ENG);

  state_t        r_state, w_state_nxt;
  mode_t         r_mode, w_sop_mode, w_mode_eff;
  logic [1:0]    r_eng, w_pfx, w_eng_eff;
  logic [3:0]    r_wr_cnt, w_wr_cnt_nxt;
  logic [4:0]    r_raw_cnt, w_raw_cnt_inc;
  logic [TW-1:0] r_timer;
  logic [63:0]   r_buf [2][8];
  logic [1:0]    r_full, r_berr;
  logic          r_wp, r_rp;
  logic [2:0]    r_err, w_err_set;
  logic          w_acc, w_word, w_wr_ok, w_hs, w_commit, w_merr_wr, w_merr_end;

  assign s_ready       = rst_n & (((r_state == IDLE) & ~r_full[r_wp]) | (r_state == STREAM));
  assign w_acc         = s_valid & s_ready;
  assign w_hs          = m_valid & m_ready;
  assign w_wr_ok       = wr_valid & ((r_state == STREAM) | (r_state == DRAIN)) & (r_wr_cnt < 4'd8);
  assign w_wr_cnt_nxt  = r_wr_cnt + {3'b0, w_wr_ok};
  assign w_raw_cnt_inc = (r_raw_cnt == 5'd31) ? r_raw_cnt : r_raw_cnt + 5'd1;
  assign m_valid       = r_full[r_rp];
  assign m_err         = r_full[r_rp] & r_berr[r_rp];
  assign err_o         = r_err;

  always_comb begin
    w_pfx = s_data[31:30];
    if ({1'b0, w_pfx} < NE)  w_sop_mode = M_ENG;
    else if (w_pfx == 2'd3)  w_sop_mode = M_RAW;
    else                     w_sop_mode = M_DROP;
    w_mode_eff = s_sop ? w_sop_mode : r_mode;
    w_eng_eff  = s_sop ? w_pfx : r_eng;
    // An accepted word belongs to a packet unless it is a stray non-sop word in IDLE.
    w_word     = w_acc & (s_sop | (r_state == STREAM));
    m_data     = '0;
    for (int k = 0; k < 8; k++) m_data[k*64 +: 64] = r_buf[r_rp][k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = '0;
    w_commit    = 1'b0;
    w_merr_wr   = 1'b0;
    w_merr_end  = 1'b0;
    if (wr_valid & ~w_wr_ok) w_err_set[2] = 1'b1;
    if (w_wr_ok & (wr_addr != r_wr_cnt)) begin
      w_err_set[2] = 1'b1;
      w_merr_wr    = 1'b1;
    end
    if (w_acc & ~w_word) w_err_set[2] = 1'b1;
    case (r_state)
      DRAIN: begin
        if (w_wr_cnt_nxt == 4'd8) w_commit = 1'b1;
        else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
          w_err_set[1] = 1'b1;
          w_merr_end   = 1'b1;
          w_commit     = 1'b1;
        end
      end
      OUT:     if (w_hs) w_state_nxt = IDLE;
      default: ;
    endcase
    if (w_acc & s_sop) begin
      w_state_nxt = STREAM;
      if (r_state == STREAM)     w_err_set[2] = 1'b1;
      if (w_sop_mode == M_DROP)  w_err_set[0] = 1'b1;
    end
    if (w_word & s_eop) begin
      case (w_mode_eff)
        M_RAW: begin
          w_commit = 1'b1;
          if (s_sop | (w_raw_cnt_inc != 5'd16)) begin
            w_err_set[2] = 1'b1;
            w_merr_end   = 1'b1;
          end
        end
        M_ENG: begin
          if (~s_sop & (w_wr_cnt_nxt == 4'd8)) w_commit = 1'b1;
          else                                 w_state_nxt = DRAIN;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
`ifdef AIDC_LITE_DCTRL_DBUF_EN
    if (w_commit) w_state_nxt = IDLE;
`else
    if (w_commit) w_state_nxt = OUT;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= M_ENG;  r_eng <= '0;  r_wr_cnt <= '0;  r_raw_cnt <= '0;  r_timer <= '0;
      r_full <= '0;  r_berr <= '0;  r_wp <= 1'b0;  r_rp <= 1'b0;  r_err <= '0;
      eng_valid <= '0;  eng_sop <= 1'b0;  eng_eop <= 1'b0;  eng_data <= '0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 8; k++) r_buf[b][k] <= '0;
    end else begin
      r_err     <= (r_err & ~{3{err_clr}}) | w_err_set;
      r_timer   <= (r_state == DRAIN) ? r_timer + 1'b1 : '0;
      eng_valid <= '0;
      eng_sop   <= 1'b0;
      eng_eop   <= 1'b0;
      eng_data  <= '0;
      if (w_word & (w_mode_eff == M_ENG)) begin
        eng_valid <= NUM_ENG'(1) << w_eng_eff;
        eng_sop   <= s_sop;
        eng_eop   <= s_eop;
        eng_data  <= s_data;
      end
      // Raw word j lands in entry j>>1, even words in the upper half.
      if (w_word & ~s_sop & (r_mode == M_RAW)) begin
        r_raw_cnt <= w_raw_cnt_inc;
        if (~r_raw_cnt[4]) begin
          if (r_raw_cnt[0]) r_buf[r_wp][r_raw_cnt[3:1]][31:0]  <= s_data;
          else              r_buf[r_wp][r_raw_cnt[3:1]][63:32] <= s_data;
        end
      end
      if (w_wr_ok) begin
        r_wr_cnt <= w_wr_cnt_nxt;
        if (~wr_addr[3]) r_buf[r_wp][wr_addr[2:0]] <= wr_data;
      end
      if (w_acc & s_sop) begin
        r_mode    <= w_sop_mode;
        r_eng     <= w_pfx;
        r_wr_cnt  <= '0;
        r_raw_cnt <= '0;
        r_berr[r_wp] <= w_merr_end;
        for (int k = 0; k < 8; k++) r_buf[r_wp][k] <= '0;
      end else begin
        r_berr[r_wp] <= r_berr[r_wp] | w_merr_wr | w_merr_end;
      end
      if (w_commit) begin
        r_full[r_wp] <= 1'b1;
`ifdef AIDC_LITE_DCTRL_DBUF_EN
        r_wp <= ~r_wp;
`endif
      end
      if (w_hs) begin
        r_full[r_rp] <= 1'b0;
`ifdef AIDC_LITE_DCTRL_DBUF_EN
        r_rp <= ~r_rp;
`endif
      end
    end
  end
endmodule
